// File: rtl/qspi_ahb_slave_ctrl.sv
// rtl/qspi_ahb_slave_ctrl.sv - AHB slave control FSM for config accesses and XIP flash reads
module qspi_ahb_slave_ctrl #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic       h_clk,
   input  logic       h_rstn,
   input  logic       h_sel,
   input  logic [1:0] h_trans,
   input  logic       h_write,
   input  logic [2:0] h_burst,
   input  logic       cfg_reg_wr,
   input  logic       enter_xip_mode,
   input  logic       addr_err,
   input  logic       xip_data_valid,
   input  logic       xip_idle,
   output logic       h_ready,
   output logic [1:0] h_resp,
   output logic       cfg_reg_wr_en,
   output logic       load_h_addr,
   output logic       load_h_burst,
   output logic       xip_start,
   output logic       xip_next,
   output logic       xip_stop
);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG_WR, S_XIP_REQ, S_XIP_WAIT, S_XIP_STOP, S_XIP_ABORT, S_ERR1, S_ERR2
   } state_t;

   state_t          r_state;
   state_t          w_nxt;
   logic            r_ready;
   logic [1:0]      r_resp;
   logic            r_cfg_en;
   logic            r_start;
   logic            r_abort_stop;
   logic [4:0]      r_beats;
   logic            r_incr;
   logic            r_gap;
   logic [TO_W-1:0] r_to;

   logic            w_vld;
   logic            w_dec;
   logic            w_wrap;
   logic            w_dec_err;
   logic            w_dec_cfg;
   logic            w_dec_xip;
   logic            w_dec_busy;
   logic            w_in_wait;
   logic            w_fetch_done;
   logic            w_accept;
   logic [4:0]      w_left;
   logic            w_more;
   logic            w_next;
   logic            w_hold;
   logic            w_end;
   logic            w_timeout;
   logic [4:0]      w_beat_load;
   logic            w_unused_write;

   // h_write is already folded into cfg_reg_wr / enter_xip_mode by the datapath
   assign w_unused_write = h_write;

   assign w_vld      = h_sel & h_ready & h_trans[1];
   assign w_dec      = w_vld & ((r_state == S_IDLE) | (r_state == S_CFG_WR) | (r_state == S_ERR2));
   assign w_wrap     = (h_burst == 3'b010) | (h_burst == 3'b100) | (h_burst == 3'b110);
   assign w_dec_err  = w_dec & (addr_err | w_wrap);
   assign w_dec_cfg  = w_dec & ~w_dec_err & cfg_reg_wr;
   assign w_dec_xip  = w_dec & ~w_dec_err & ~cfg_reg_wr & enter_xip_mode & xip_idle;
   assign w_dec_busy = w_dec & ~w_dec_err & ~cfg_reg_wr & enter_xip_mode & ~xip_idle;

   // A beat completes on flash data; r_gap marks a BUSY pause with no fetch outstanding,
   // during which the bus is ready and the next SEQ can be accepted at once.
   assign w_in_wait    = (r_state == S_XIP_WAIT);
   assign w_fetch_done = w_in_wait & ~r_gap & xip_data_valid;
   assign w_accept     = w_in_wait & (r_gap | xip_data_valid);
   assign w_left       = r_gap ? r_beats : (r_beats - 5'd1);
   assign w_more       = r_incr | (w_left != 5'd0);
   assign w_next       = w_accept & w_more & h_sel & (h_trans == 2'b11);
   assign w_hold       = w_accept & ~w_next & h_sel & (h_trans == 2'b01);
   assign w_end        = w_accept & ~w_next & ~w_hold;
   assign w_timeout    = w_in_wait & ~w_accept & (r_to == TO_W'(TIMEOUT_CYCLES - 1));

   assign h_ready       = w_in_wait ? w_accept : r_ready;
   assign h_resp        = r_resp;
   assign cfg_reg_wr_en = r_cfg_en;
   assign xip_start     = r_start;
   assign xip_next      = w_next;
   assign xip_stop      = w_end | r_abort_stop;
   assign load_h_addr   = w_dec_xip | w_next;
   assign load_h_burst  = w_dec_xip;

   // Beats per fixed-length burst; INCR loads a dummy count and is tracked by r_incr
   always_comb begin
      w_beat_load = 5'd1;
      case (h_burst)
         3'b011:  w_beat_load = 5'd4;
         3'b101:  w_beat_load = 5'd8;
         3'b111:  w_beat_load = 5'd16;
         default: w_beat_load = 5'd1;
      endcase
   end

   // Next-state selection
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE, S_CFG_WR, S_ERR2: begin
            if (w_dec_err)       w_nxt = S_ERR1;
            else if (w_dec_cfg)  w_nxt = S_CFG_WR;
            else if (w_dec_xip)  w_nxt = S_XIP_REQ;
            else if (w_dec_busy) w_nxt = S_XIP_STOP;
            else                 w_nxt = S_IDLE;
         end
         S_XIP_REQ:   w_nxt = S_XIP_WAIT;
         S_XIP_WAIT: begin
            if (w_timeout)  w_nxt = S_XIP_ABORT;
            else if (w_end) w_nxt = S_XIP_STOP;
         end
         S_XIP_STOP:  if (xip_idle) w_nxt = S_IDLE;
         S_XIP_ABORT: if (xip_idle) w_nxt = S_ERR1;
         S_ERR1:      w_nxt = S_ERR2;
         default:     w_nxt = S_IDLE;
      endcase
   end

   // FSM state and its registered outputs, derived from the state being entered
   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         r_state      <= S_IDLE;
         r_ready      <= 1'b1;
         r_resp       <= 2'b00;
         r_cfg_en     <= 1'b0;
         r_start      <= 1'b0;
         r_abort_stop <= 1'b0;
      end else begin
         r_state      <= w_nxt;
         r_ready      <= (w_nxt == S_IDLE) | (w_nxt == S_CFG_WR) | (w_nxt == S_ERR2);
         r_resp       <= ((w_nxt == S_ERR1) | (w_nxt == S_ERR2)) ? 2'b01 : 2'b00;
         r_cfg_en     <= (w_nxt == S_CFG_WR);
         r_start      <= (w_nxt == S_XIP_REQ);
         r_abort_stop <= (w_nxt == S_XIP_ABORT) & (r_state != S_XIP_ABORT);
      end
   end

   // Beat counter, BUSY-gap flag and per-beat timeout counter
   always_ff @(posedge h_clk or negedge h_rstn) begin
      if (!h_rstn) begin
         r_beats <= 5'd0;
         r_incr  <= 1'b0;
         r_gap   <= 1'b0;
         r_to    <= '0;
      end else begin
         if (w_dec_xip) begin
            r_beats <= w_beat_load;
            r_incr  <= (h_burst == 3'b001);
            r_gap   <= 1'b0;
         end
         if (r_state == S_XIP_REQ) begin
            r_to <= '0;
         end
         if (w_in_wait) begin
            if (w_fetch_done)
               r_to <= '0;
            else if (!r_gap)
               r_to <= r_to + TO_W'(1);
            if (w_fetch_done && !r_incr)
               r_beats <= r_beats - 5'd1;
            if (w_next)
               r_gap <= 1'b0;
            else if (w_hold)
               r_gap <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_qspi_ahb_slave_ctrl.sv
// tb/tb_qspi_ahb_slave_ctrl.sv - randomized self-checking bench for qspi_ahb_slave_ctrl
module tb_qspi_ahb_slave_ctrl;

   localparam int TO = 16;

   logic       h_clk = 1'b0;
   logic       h_rstn;
   logic       h_sel;
   logic [1:0] h_trans;
   logic       h_write;
   logic [2:0] h_burst;
   logic       cfg_reg_wr;
   logic       enter_xip_mode;
   logic       addr_err;
   logic       xip_data_valid;
   logic       xip_idle;
   logic       h_ready;
   logic [1:0] h_resp;
   logic       cfg_reg_wr_en;
   logic       load_h_addr;
   logic       load_h_burst;
   logic       xip_start;
   logic       xip_next;
   logic       xip_stop;

   always #5 h_clk = ~h_clk;

   qspi_ahb_slave_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
      .h_clk(h_clk), .h_rstn(h_rstn), .h_sel(h_sel), .h_trans(h_trans), .h_write(h_write),
      .h_burst(h_burst), .cfg_reg_wr(cfg_reg_wr), .enter_xip_mode(enter_xip_mode),
      .addr_err(addr_err), .xip_data_valid(xip_data_valid), .xip_idle(xip_idle),
      .h_ready(h_ready), .h_resp(h_resp), .cfg_reg_wr_en(cfg_reg_wr_en),
      .load_h_addr(load_h_addr), .load_h_burst(load_h_burst), .xip_start(xip_start),
      .xip_next(xip_next), .xip_stop(xip_stop)
   );

   int n_chk = 0;
   int n_err = 0;

   // flash engine model: absolute cycle at which data / idle appear
   int cyc_n = 0;
   int valid_at = -1;
   int idle_at = 0;
   int q_d = 1;
   int lat_q[$];
   int lat[16];
   int busy[16];

   logic       s_ready, s_start, s_next, s_stop, s_cfg, s_la, s_lb;
   logic [1:0] s_resp;
   int cnt_start = 0, cnt_next = 0, cnt_stop = 0, cnt_cfg = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_samples();
      s_ready = 1'b1; s_start = 1'b0; s_next = 1'b0; s_stop = 1'b0;
      s_cfg = 1'b0; s_la = 1'b0; s_lb = 1'b0; s_resp = 2'b00;
   endtask

   // one bus cycle: flash model reacts to last cycle's strobes, master drives, outputs sampled at negedge
   task automatic cycle(input logic [1:0] tr, input logic sel, input logic cfg, input logic xip,
                        input logic aerr, input logic [2:0] bu);
      int l;
      @(posedge h_clk);
      #1;
      cyc_n++;
      if (s_start || s_next) begin
         l = 1;
         if (lat_q.size() > 0) l = lat_q.pop_front();
         valid_at = cyc_n - 1 + l;
      end
      if (s_start) idle_at = 1 << 30;
      if (s_stop) begin
         valid_at = -1;
         idle_at  = cyc_n - 1 + q_d;
      end
      xip_data_valid = (cyc_n == valid_at);
      xip_idle       = (cyc_n >= idle_at);
      h_trans = tr; h_sel = sel; cfg_reg_wr = cfg; enter_xip_mode = xip;
      addr_err = aerr; h_burst = bu; h_write = cfg;
      @(negedge h_clk);
      s_ready = h_ready; s_resp = h_resp; s_start = xip_start; s_next = xip_next;
      s_stop = xip_stop; s_cfg = cfg_reg_wr_en; s_la = load_h_addr; s_lb = load_h_burst;
      cnt_start += int'(s_start); cnt_next += int'(s_next);
      cnt_stop += int'(s_stop); cnt_cfg += int'(s_cfg);
   endtask

   task automatic idle_cycle();
      cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   function automatic int beats_of(input logic [2:0] bu);
      case (bu)
         3'b011:  return 4;
         3'b101:  return 8;
         3'b111:  return 16;
         default: return 1;
      endcase
   endfunction

   task automatic cfg_write(input int n);
      int c0;
      c0 = cnt_cfg;
      for (int i = 0; i < n; i++) begin
         cycle(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
         check("cfgw_addr_ready", s_ready, 1);
         if (i > 0) check("cfgw_b2b_en", s_cfg, 1);
      end
      idle_cycle();
      check("cfgw_data_en", s_cfg, 1);
      check("cfgw_data_ready", s_ready, 1);
      check("cfgw_data_resp", s_resp, 0);
      idle_cycle();
      check("cfgw_en_drop", s_cfg, 0);
      check("cfgw_count", cnt_cfg - c0, n);
   endtask

   task automatic cfg_read();
      cycle(2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
      idle_cycle();
      check("cfgr_ready", s_ready, 1);
      check("cfgr_resp", s_resp, 0);
      check("cfgr_no_wr", s_cfg, 0);
   endtask

   task automatic err_txn(input logic aerr, input logic xip, input logic [2:0] bu);
      int c0;
      c0 = cnt_start;
      cycle(2'b10, 1'b1, !xip, xip, aerr, bu);
      check("err_addr_ready", s_ready, 1);
      idle_cycle();
      check("err1_ready", s_ready, 0);
      check("err1_resp", s_resp, 1);
      check("err1_no_wr", s_cfg, 0);
      idle_cycle();
      check("err2_ready", s_ready, 1);
      check("err2_resp", s_resp, 1);
      idle_cycle();
      check("err_done_resp", s_resp, 0);
      check("err_no_start", cnt_start - c0, 0);
   endtask

   task automatic xip_burst(input logic [2:0] bu, input int nb);
      int w, c0s, c0n, c0p;
      logic last;
      logic [1:0] tr;
      for (int i = 0; i < nb; i++) lat_q.push_back(lat[i]);
      c0s = cnt_start; c0n = cnt_next; c0p = cnt_stop;
      cycle(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, bu);
      check("xip_load_addr", s_la, 1);
      check("xip_load_burst", s_lb, 1);
      check("xip_addr_ready", s_ready, 1);
      for (int i = 0; i < nb; i++) begin
         last = (i == nb - 1);
         tr = last ? 2'b00 : (busy[i] > 0 ? 2'b01 : 2'b11);
         w = 0;
         for (int k = 0; k < 200; k++) begin
            cycle(tr, !last, 1'b0, 1'b0, 1'b0, bu);
            if (s_ready) break;
            w++;
         end
         check("beat_wait", w, (i == 0) ? lat[i] : lat[i] - 1);
         check("beat_resp", s_resp, 0);
         check("beat_next", s_next, (!last && busy[i] == 0));
         check("beat_stop", s_stop, last);
         if (!last && busy[i] > 0) begin
            for (int b = 1; b < busy[i]; b++) begin
               cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, bu);
               check("busy_ready", s_ready, 1);
               check("busy_no_next", s_next, 0);
            end
            cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, bu);
            check("seq_after_busy_next", s_next, 1);
            check("seq_after_busy_ready", s_ready, 1);
         end
      end
      w = 0;
      for (int k = 0; k < 200; k++) begin
         idle_cycle();
         if (s_ready) break;
         w++;
      end
      check("stop_wait", w, q_d);
      check("start_count", cnt_start - c0s, 1);
      check("next_count", cnt_next - c0n, nb - 1);
      check("stop_count", cnt_stop - c0p, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, h_ready, 1);
      check({tag, "_resp"}, h_resp, 0);
      check({tag, "_strobes"}, {cfg_reg_wr_en, load_h_addr, load_h_burst, xip_start, xip_next, xip_stop}, 0);
   endtask

   task automatic flash_model_reset();
      valid_at = -1; idle_at = 0; xip_data_valid = 1'b0; xip_idle = 1'b1;
      lat_q.delete();
      clear_samples();
   endtask

   initial begin
      int ts, t0, te, w, a, op, bsel, nb;
      logic [2:0] bu;
      h_rstn = 1'b0; h_sel = 1'b0; h_trans = 2'b00; h_write = 1'b0; h_burst = 3'b000;
      cfg_reg_wr = 1'b0; enter_xip_mode = 1'b0; addr_err = 1'b0;
      flash_model_reset();
      #12;
      check_reset_outputs("rst");
      @(negedge h_clk);
      h_rstn = 1'b1;

      // back-to-back config writes
      cfg_write(2);
      cfg_read();

      // SINGLE read, data after 5 cycles
      lat[0] = 5; busy[0] = 0; q_d = 2;
      xip_burst(3'b000, 1);

      // INCR4 with BUSY between beats 2 and 3
      for (int i = 0; i < 4; i++) begin lat[i] = 2; busy[i] = 0; end
      busy[1] = 1;
      xip_burst(3'b011, 4);

      // out-of-range address with a concurrent config write flag
      err_txn(1'b1, 1'b0, 3'b000);

      // XIP address while the flash engine is still busy: held off, no pulses
      idle_at = cyc_n + 3;
      ts = cnt_start + cnt_stop;
      cycle(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
      a = cyc_n;
      check("busy_xip_no_load", s_la, 0);
      w = 0;
      for (int k = 0; k < 50; k++) begin
         idle_cycle();
         if (s_ready) break;
         w++;
      end
      check("busy_xip_hold", w, idle_at - a);
      check("busy_xip_no_pulse", cnt_start + cnt_stop - ts, 0);

      // timeout: data never arrives
      lat_q.push_back(100000); q_d = 2;
      cycle(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
      t0 = -1000; ts = -1; w = 0;
      for (int k = 0; k < 100; k++) begin
         idle_cycle();
         if (s_start) t0 = cyc_n;
         if (s_ready) w++;
         if (s_stop) begin ts = cyc_n; break; end
      end
      check("to_stop_delay", ts - t0, TO + 1);
      check("to_ready_low", w, 0);
      te = -1;
      for (int k = 0; k < 50; k++) begin
         idle_cycle();
         if (s_resp == 2'b01) begin te = cyc_n; break; end
      end
      check("to_err_delay", te - ts, q_d + 1);
      check("to_err1_ready", s_ready, 0);
      idle_cycle();
      check("to_err2_ready", s_ready, 1);
      check("to_err2_resp", s_resp, 1);
      idle_cycle();
      check("to_after_resp", s_resp, 0);

      // reset in the middle of an INCR8
      for (int i = 0; i < 8; i++) lat_q.push_back(2);
      cycle(2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 3'b101);
      for (int k = 0; k < 6; k++) cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101);
      #2;
      h_rstn = 1'b0; h_trans = 2'b00; h_sel = 1'b0; enter_xip_mode = 1'b0;
      #1;
      check_reset_outputs("midrst");
      flash_model_reset();
      repeat (2) @(posedge h_clk);
      @(negedge h_clk);
      h_rstn = 1'b1;
      lat[0] = 3; busy[0] = 0; q_d = 1;
      xip_burst(3'b000, 1);

      // randomized mix of transactions
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: cfg_write($urandom_range(1, 3));
            1: cfg_read();
            2: err_txn(1'b1, $urandom_range(0, 1), 3'b000);
            3: begin
               bsel = $urandom_range(0, 2);
               bu = (bsel == 0) ? 3'b010 : (bsel == 1) ? 3'b100 : 3'b110;
               err_txn(1'b0, 1'b1, bu);
            end
            default: begin
               bsel = $urandom_range(0, 4);
               case (bsel)
                  0: bu = 3'b000;
                  1: bu = 3'b011;
                  2: bu = 3'b101;
                  3: bu = 3'b111;
                  default: bu = 3'b001;
               endcase
               nb = (bu == 3'b001) ? $urandom_range(1, 6) : beats_of(bu);
               for (int i = 0; i < 16; i++) begin
                  lat[i]  = $urandom_range(1, 4);
                  busy[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
               end
               q_d = $urandom_range(1, 3);
               xip_burst(bu, nb);
            end
         endcase
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
